// File: rtl/prod_accumulator.sv
// Sums a stream of signed 32-bit products into a wide accumulator and presents one result per vector.
// Each result is held until downstream takes it; the next vector's first beat can be accepted in that same cycle.
module prod_accumulator #(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  input  logic             in_last,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [31:0]      out_sat,
  output logic             out_ovf,
  output logic [8:0]       out_count
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [8:0] CNT_MAX = 9'(N_TERMS);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [31:0]        out_sat_q, out_sat_d;
  logic               out_ovf_q, out_ovf_d;
  logic [8:0]         out_count_q, out_count_d;

  logic               accept;
  logic               closing;
  logic               sum_fits;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   base_acc;
  logic [8:0]         base_cnt;
  logic [ACC_W-1:0]   sum;
  logic [8:0]         cnt_inc;
  logic [31:0]        sat_val;
  logic [ACC_W-32:0]  sum_hi;

  assign in_ready  = (state_q == ACCUM) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;

  // In HOLD, an accepted beat starts a fresh vector, so it adds onto zero.
  always_comb begin
    prod_ext = {{(ACC_W-32){in_prod[31]}}, in_prod};
    base_acc = (state_q == HOLD) ? '0 : acc_q;
    base_cnt = (state_q == HOLD) ? 9'd0 : cnt_q;
    sum      = base_acc + prod_ext;
    cnt_inc  = base_cnt + 9'd1;
    closing  = in_last | (cnt_inc == CNT_MAX);
    // Fits in 32 bits when every bit from 31 upward matches the sign.
    sum_hi   = sum[ACC_W-1:31];
    sum_fits = (&sum_hi) | ~(|sum_hi);
    if (sum_fits)          sat_val = sum[31:0];
    else if (sum[ACC_W-1]) sat_val = 32'h8000_0000;
    else                   sat_val = 32'h7FFF_FFFF;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    case (state_q)
      ACCUM: begin
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (closing) begin
            state_d     = HOLD;
            acc_d       = '0;
            cnt_d       = '0;
            out_sum_d   = sum;
            out_sat_d   = sat_val;
            out_ovf_d   = ~sum_fits;
            out_count_d = cnt_inc;
          end else begin
            acc_d = sum;
            cnt_d = cnt_inc;
          end
        end
      end
      HOLD: begin
        // clr is ignored here so a presented result is never withdrawn.
        if (out_ready) begin
          if (accept && closing) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_sum_d   = sum;
            out_sat_d   = sat_val;
            out_ovf_d   = ~sum_fits;
            out_count_d = cnt_inc;
          end else if (accept) begin
            state_d = ACCUM;
            acc_d   = sum;
            cnt_d   = cnt_inc;
          end else begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_sat_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 SHALL have parameter N_TERMS, default 8, meaning the maximum number of products summed per vector (legal range 1..256).
REQ-002 SHALL have parameter ACC_W, default 40, meaning the accumulator width in bits (legal: ACC_W >= 40).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning in_prod/in_last are valid this cycle.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts a beat this cycle.
REQ-007 SHALL have port in_prod  input  32  meaning a signed two's-complement product from the 16x16 Booth multiplier.
REQ-008 SHALL have port in_last  input  1  meaning this beat closes the current vector.
REQ-009 SHALL have port clr  input  1  meaning synchronous abort of the partial vector.
REQ-010 SHALL have port out_valid  output  1  meaning the result is valid.
REQ-011 SHALL have port out_ready  input  1  meaning downstream takes the result this cycle.
REQ-012 SHALL have port out_sum  output  ACC_W  meaning the signed full-precision sum.
REQ-013 SHALL have port out_sat  output  32  meaning out_sum clamped to the signed 32-bit range.
REQ-014 SHALL have port out_ovf  output  1  meaning out_sat was clamped.
REQ-015 SHALL have port out_count  output  9  meaning the number of products in the result (1..256).

Function
REQ-016 SHALL implement a two-state FSM: ACCUM (collecting) and HOLD (result presented); out_valid SHALL be 1 exactly in HOLD.
REQ-017 SHALL define a beat as accepted when in_valid && in_ready at a rising clk edge.
REQ-018 SHALL drive in_ready = 1 in ACCUM and in_ready = out_ready in HOLD; in_ready SHALL NOT depend on in_valid.
REQ-019 In ACCUM, SHALL add each accepted in_prod, sign-extended to ACC_W, to acc and increment count.
REQ-020 SHALL close a vector on an accepted beat with in_last = 1, or on the beat that makes count = N_TERMS, whichever comes first.
REQ-021 On the closing beat, SHALL enter HOLD on the next edge with out_sum = acc including that beat, which gives a one-cycle latency from the last beat to out_valid.
REQ-022 In HOLD, out_sum, out_sat, out_ovf and out_count SHALL stay stable until out_valid && out_ready.
REQ-023 If a HOLD handshake occurs with no accepted beat, SHALL return to ACCUM with acc = 0 and count = 0.
REQ-024 If a HOLD handshake and an accepted beat occur in the same cycle, SHALL load acc = sext(in_prod) and count = 1; if that beat closes a vector, SHALL remain in HOLD with the new result, otherwise SHALL go to ACCUM.
REQ-025 SHALL set out_sat = 0x7FFFFFFF when out_sum > 2^31-1, 0x80000000 when out_sum < -2^31, and out_sum[31:0] otherwise; out_ovf SHALL be 1 only in the clamped cases.
REQ-026 Arithmetic: acc SHALL never wrap, because ACC_W >= 32 + log2(256).
REQ-027 clr in ACCUM SHALL zero acc and count and SHALL discard any beat accepted in the same cycle (clr has priority).
REQ-028 clr in HOLD SHALL have no effect; the presented result SHALL NOT be withdrawn.
REQ-029 A vector with in_last on its first beat SHALL give out_count = 1.

Reset
REQ-030 On rst_n = 0, SHALL immediately (asynchronously) set state = ACCUM, acc = 0, count = 0, out_valid = 0, out_sum = 0, out_sat = 0, out_ovf = 0 and out_count = 0.
REQ-031 Reset asserted mid-vector or in HOLD SHALL discard all partial and held results.
REQ-032 After rst_n deasserts, in_ready SHALL be 1 from the first edge.

Verification
REQ-033 Products -15, 40, -25 with in_last on the 3rd beat, out_ready = 1 -> one cycle later out_valid = 1, out_sum = 0, out_count = 3, out_ovf = 0.
REQ-034 N_TERMS = 8 with 8 beats of 0x3FFF0001 and in_last = 0 -> auto-close; out_sum = 0x1_FFF80008, out_sat = 0x7FFFFFFF, out_ovf = 1, out_count = 8.
REQ-035 out_ready held 0 for 5 cycles in HOLD while in_valid = 1 -> in_ready = 0 and outputs stable; when out_ready rises, the next vector's first beat is accepted in the same cycle and loads acc = that product.
REQ-036 Two beats (100, 200) then clr = 1 together with beat 300, then beat 7 with in_last -> out_sum = 7, out_count = 1.
REQ-037 rst_n pulsed low while in HOLD with out_sum = 1234 -> out_valid drops without waiting for a clock edge; all outputs read 0.
REQ-038 Back-to-back single-beat vectors (in_last = 1 every cycle, out_ready = 1) of -32768*32767 = 0xC0008000 -> out_valid = 1 every cycle, out_sat = 0xC0008000, full throughput.
